// File: rtl/trace_trig_pkg.sv
// Shared types and constants for the trace trigger generator.
// Optional SEQ mode state is present only when TRACE_TRIG_SEQ_EN is defined.
package trace_trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
`ifdef TRACE_TRIG_SEQ_EN
        ST_SEQ_WAIT = 3'd2,
`endif
        ST_DELAY    = 3'd3,
        ST_PULSE    = 3'd4,
        ST_HOLDOFF  = 3'd5
    } state_e;

    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_SEQ = 2'd2;

    // Edge detector powers up "high" so an arm level held through reset is not an edge
    localparam logic ARM_EDGE_RST = 1'b1;

endpackage

// File: rtl/trace_trig_match.sv
// Combinational source evaluation: OR hit, AND hit and SEQ first-stage hit.
module trace_trig_match #(
    parameter int unsigned pNUM_SOURCES = 9
) (
    input  logic [pNUM_SOURCES-1:0] i_sources,
    input  logic [pNUM_SOURCES-1:0] i_mask,
    input  logic [pNUM_SOURCES-1:0] i_seq_first,
    output logic                    o_or_hit_c,
    output logic                    o_and_hit_c,
    output logic                    o_first_hit_c
);

    logic [pNUM_SOURCES-1:0] w_masked;

    assign w_masked      = i_sources & i_mask;
    assign o_or_hit_c    = |w_masked;
    // An empty mask must never match, even though the equality would hold
    assign o_and_hit_c   = (|i_mask) && (w_masked == i_mask);
    assign o_first_hit_c = |(i_sources & i_seq_first);

endmodule

// File: rtl/trace_trig_gen.sv
// Trigger generator: match FSM, delay/width/holdoff counter, event counter, heartbeat LED.
// Define TRACE_TRIG_SEQ_EN to build the two-stage SEQ mode (mode 2); otherwise mode 2 is OR.
module trace_trig_gen
    import trace_trig_pkg::*;
#(
    parameter int unsigned pNUM_SOURCES    = 9,
    parameter int unsigned pDELAY_WIDTH    = 16,
    parameter int unsigned pWIDTH_WIDTH    = 8,
    parameter int unsigned pCOUNT_WIDTH    = 16,
    parameter int unsigned pHEARTBEAT_BITS = 23
) (
    input  logic                       trace_clk,
    input  logic                       reset_n,
    input  logic                       I_arm,
    input  logic [1:0]                 I_mode,
    input  logic [pNUM_SOURCES-1:0]    I_mask,
    input  logic [pNUM_SOURCES-1:0]    I_seq_first,
    input  logic [pNUM_SOURCES-1:0]    I_sources,
    input  logic [pDELAY_WIDTH-1:0]    I_delay,
    input  logic [pWIDTH_WIDTH-1:0]    I_pulse_width,
    input  logic [pWIDTH_WIDTH-1:0]    I_holdoff,
    input  logic                       I_oneshot,
    output logic                       O_trig_out,
    output logic                       O_armed,
    output logic                       O_capturing,
    output logic [pCOUNT_WIDTH-1:0]    O_trig_count,
    output logic                       O_led_heartbeat
);

    localparam int unsigned CNT_W = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;

    state_e                     r_state;
    state_e                     w_state_nxt;
    state_e                     w_start_state;
    state_e                     w_done_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [CNT_W-1:0]           w_start_cnt;
    logic [CNT_W-1:0]           w_pulse_cnt;
    logic [CNT_W-1:0]           w_hold_cnt;
    logic                       r_arm_d;
    logic                       w_arm_rise;
    logic                       w_or_hit;
    logic                       w_and_hit;
    logic                       w_first_hit;
    logic                       w_match;
    logic                       w_pulse_entry;
    logic                       w_arm_entry;
    logic                       w_trig_nxt;
    logic                       w_armed_nxt;
    logic                       w_capt_nxt;
    logic                       r_trig_out;
    logic                       r_armed;
    logic                       r_capturing;
    logic [pCOUNT_WIDTH-1:0]    r_trig_count;
    logic [pHEARTBEAT_BITS-1:0] r_heartbeat;

    trace_trig_match #(
        .pNUM_SOURCES (pNUM_SOURCES)
    ) u_match (
        .i_sources     (I_sources),
        .i_mask        (I_mask),
        .i_seq_first   (I_seq_first),
        .o_or_hit_c    (w_or_hit),
        .o_and_hit_c   (w_and_hit),
        .o_first_hit_c (w_first_hit)
    );

`ifndef TRACE_TRIG_SEQ_EN
    logic w_seq_unused;
    assign w_seq_unused = w_first_hit ^ (I_mode == MODE_SEQ);
`endif

    assign w_arm_rise    = I_arm & ~r_arm_d;
    assign w_match       = (I_mode == MODE_AND) ? w_and_hit : w_or_hit;
    // Counter holds "remaining cycles minus one"; a zero width still gives one cycle
    assign w_pulse_cnt   = (I_pulse_width == '0) ? '0 : CNT_W'(I_pulse_width) - CNT_W'(1);
    assign w_hold_cnt    = CNT_W'(I_holdoff) - CNT_W'(1);
    assign w_start_state = (I_delay == '0) ? ST_PULSE : ST_DELAY;
    assign w_start_cnt   = (I_delay == '0) ? w_pulse_cnt : CNT_W'(I_delay) - CNT_W'(1);
    assign w_done_state  = I_oneshot ? ST_IDLE : ST_ARMED;
    assign w_pulse_entry = (w_state_nxt == ST_PULSE) && (r_state != ST_PULSE);
    assign w_arm_entry   = (w_state_nxt == ST_ARMED) && (r_state == ST_IDLE);

    // State and shared down-counter register
    always_ff @(posedge trace_clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and counter reload
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_arm_rise) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
`ifdef TRACE_TRIG_SEQ_EN
                if (I_mode == MODE_SEQ) begin
                    if (w_first_hit) w_state_nxt = ST_SEQ_WAIT;
                end else
`endif
                if (w_match) begin
                    w_state_nxt = w_start_state;
                    w_cnt_nxt   = w_start_cnt;
                end
            end
`ifdef TRACE_TRIG_SEQ_EN
            ST_SEQ_WAIT: begin
                if (w_or_hit) begin
                    w_state_nxt = w_start_state;
                    w_cnt_nxt   = w_start_cnt;
                end
            end
`endif
            ST_DELAY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = w_pulse_cnt;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    if (I_holdoff == '0) begin
                        w_state_nxt = w_done_state;
                    end else begin
                        w_state_nxt = ST_HOLDOFF;
                        w_cnt_nxt   = w_hold_cnt;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt == '0) w_state_nxt = w_done_state;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!I_arm) w_state_nxt = ST_IDLE;
    end

    // Output decode; a low arm kills outputs on the same edge that forces IDLE
    always_comb begin
        w_trig_nxt  = 1'b0;
        w_armed_nxt = 1'b0;
        w_capt_nxt  = 1'b0;
        if (I_arm) begin
            case (r_state)
                ST_ARMED:    w_armed_nxt = 1'b1;
`ifdef TRACE_TRIG_SEQ_EN
                ST_SEQ_WAIT: w_armed_nxt = 1'b1;
`endif
                ST_DELAY: begin
                    w_armed_nxt = 1'b1;
                    w_capt_nxt  = 1'b1;
                end
                ST_PULSE: begin
                    w_trig_nxt = 1'b1;
                    w_capt_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output registers, arm edge detector, event and heartbeat counters
    always_ff @(posedge trace_clk) begin
        if (!reset_n) begin
            r_arm_d      <= ARM_EDGE_RST;
            r_trig_out   <= 1'b0;
            r_armed      <= 1'b0;
            r_capturing  <= 1'b0;
            r_trig_count <= '0;
            r_heartbeat  <= '0;
        end else begin
            r_arm_d     <= I_arm;
            r_trig_out  <= w_trig_nxt;
            r_armed     <= w_armed_nxt;
            r_capturing <= w_capt_nxt;
            if (w_arm_entry) begin
                r_trig_count <= '0;
            end else if (w_pulse_entry && (r_trig_count != '1)) begin
                r_trig_count <= r_trig_count + pCOUNT_WIDTH'(1);
            end
            if (!r_trig_out) r_heartbeat <= r_heartbeat + pHEARTBEAT_BITS'(1);
        end
    end

    assign O_trig_out      = r_trig_out;
    assign O_armed         = r_armed;
    assign O_capturing     = r_capturing;
    assign O_trig_count    = r_trig_count;
    assign O_led_heartbeat = r_heartbeat[pHEARTBEAT_BITS-1];

endmodule

// File: tb/tb_trace_trig_gen.sv
// Directed bench for trace_trig_gen; expectations follow TRACE_TRIG_SEQ_EN when it is defined.
module tb_trace_trig_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        arm;
    logic [1:0]  mode;
    logic [8:0]  mask;
    logic [8:0]  seq_first;
    logic [8:0]  sources;
    logic [15:0] delay;
    logic [7:0]  pulse_width;
    logic [7:0]  holdoff;
    logic        oneshot;
    logic        trig_out;
    logic        armed;
    logic        capturing;
    logic [3:0]  trig_count;
    logic        led;

    int n_assert = 0;
    int n_fail   = 0;

    trace_trig_gen #(
        .pNUM_SOURCES    (9),
        .pDELAY_WIDTH    (16),
        .pWIDTH_WIDTH    (8),
        .pCOUNT_WIDTH    (4),
        .pHEARTBEAT_BITS (4)
    ) dut (
        .trace_clk       (clk),
        .reset_n         (reset_n),
        .I_arm           (arm),
        .I_mode          (mode),
        .I_mask          (mask),
        .I_seq_first     (seq_first),
        .I_sources       (sources),
        .I_delay         (delay),
        .I_pulse_width   (pulse_width),
        .I_holdoff       (holdoff),
        .I_oneshot       (oneshot),
        .O_trig_out      (trig_out),
        .O_armed         (armed),
        .O_capturing     (capturing),
        .O_trig_count    (trig_count),
        .O_led_heartbeat (led)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic [8:0] msk, input logic [15:0] d,
                       input logic [7:0] w, input logic [7:0] h, input logic os);
        mode = m; mask = msk; delay = d; pulse_width = w; holdoff = h; oneshot = os;
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b1; seq_first = 9'h100; sources = '0;
        cfg(2'd0, 9'h000, 16'd0, 8'd1, 8'd0, 1'b1);
        step(2);
        check("rst_trig", trig_out, 0);
        check("rst_armed", armed, 0);
        check("rst_capt", capturing, 0);
        check("rst_count", trig_count, 0);
        check("rst_led", led, 0);
        reset_n = 1'b1;
        step(3);
        check("arm_held_thru_reset", armed, 0);

        // OR, delay 5, width 3, one-shot
        arm = 1'b0; step(1);
        cfg(2'd0, 9'h003, 16'd5, 8'd3, 8'd0, 1'b1);
        arm = 1'b1; step(2);
        check("or_armed", armed, 1);
        sources = 9'h002; step(1); sources = '0;
        check("or_t0_trig", trig_out, 0);
        step(5);
        check("or_t5_trig", trig_out, 0);
        check("or_t5_capt", capturing, 1);
        step(1);
        check("or_t6_trig", trig_out, 1);
        check("or_t6_armed", armed, 0);
        check("or_t6_count", trig_count, 1);
        step(2);
        check("or_t8_trig", trig_out, 1);
        step(1);
        check("or_t9_trig", trig_out, 0);
        check("or_t9_armed", armed, 0);
        check("or_t9_capt", capturing, 0);
        sources = 9'h002; step(8); sources = '0;
        check("or_oneshot_no_retrig", trig_out, 0);
        check("or_final_count", trig_count, 1);

        // AND, mask 0x005, delay 0, width 0 (acts as 1)
        arm = 1'b0; step(1);
        cfg(2'd1, 9'h005, 16'd0, 8'd0, 8'd0, 1'b1);
        arm = 1'b1; step(2);
        check("and_count_cleared", trig_count, 0);
        sources = 9'h001; step(1); sources = '0;
        step(3);
        check("and_partial_trig", trig_out, 0);
        check("and_partial_armed", armed, 1);
        sources = 9'h005; step(1); sources = '0;
        check("and_t0_trig", trig_out, 0);
        step(1);
        check("and_t1_trig", trig_out, 1);
        step(1);
        check("and_t2_trig", trig_out, 0);
        check("and_count", trig_count, 1);

        // Re-arm, width 3, holdoff 4, source held: period 8
        arm = 1'b0; step(1);
        cfg(2'd0, 9'h001, 16'd0, 8'd3, 8'd4, 1'b0);
        arm = 1'b1; sources = 9'h001;
        step(2);
        check("rearm_a1_trig", trig_out, 0);
        step(1);
        check("rearm_a2_trig", trig_out, 1);
        step(2);
        check("rearm_a4_trig", trig_out, 1);
        step(1);
        check("rearm_a5_trig", trig_out, 0);
        step(4);
        check("rearm_a9_trig", trig_out, 0);
        check("rearm_a9_armed", armed, 1);
        step(1);
        check("rearm_a10_trig", trig_out, 1);
        check("rearm_a10_count", trig_count, 2);
        step(128);
        check("rearm_saturated", trig_count, 4'hF);
        check("rearm_still_pulsing", trig_out, 1);

        // Disarm mid-pulse
        arm = 1'b0; step(1); sources = '0;
        check("disarm_trig", trig_out, 0);
        check("disarm_armed", armed, 0);
        check("disarm_capt", capturing, 0);
        step(1);
        check("disarm_idle_armed", armed, 0);
        check("disarm_count_hold", trig_count, 4'hF);

        // Reset mid-delay, arm held high, then heartbeat cadence
        cfg(2'd0, 9'h001, 16'd10, 8'd2, 8'd0, 1'b1);
        arm = 1'b1; step(2);
        sources = 9'h001; step(1); sources = '0;
        step(3);
        check("delay_capt", capturing, 1);
        reset_n = 1'b0; step(1);
        check("midrst_trig", trig_out, 0);
        check("midrst_armed", armed, 0);
        check("midrst_capt", capturing, 0);
        check("midrst_count", trig_count, 0);
        check("midrst_led", led, 0);
        reset_n = 1'b1;
        step(7);
        check("hb_7_led", led, 0);
        check("postrst_no_arm", armed, 0);
        step(1);
        check("hb_8_led", led, 1);
        step(8);
        check("hb_16_led", led, 0);
        check("postrst_trig", trig_out, 0);
        check("postrst_armed2", armed, 0);

        // SEQ mode: final 0x001, first stage 0x100
        arm = 1'b0; step(1);
        cfg(2'd2, 9'h001, 16'd0, 8'd1, 8'd0, 1'b1);
        seq_first = 9'h100;
        arm = 1'b1; step(2);
        sources = 9'h001; step(1); sources = '0;
        step(1);
`ifdef TRACE_TRIG_SEQ_EN
        check("seq_final_only_trig", trig_out, 0);
        check("seq_final_only_armed", armed, 1);
`else
        check("seq_final_only_trig", trig_out, 1);
        check("seq_final_only_armed", armed, 0);
`endif
        step(2);
        sources = 9'h101; step(1); sources = '0;
        step(2);
        check("seq_same_cycle_trig", trig_out, 0);
`ifdef TRACE_TRIG_SEQ_EN
        check("seq_wait_armed", armed, 1);
`else
        check("seq_wait_armed", armed, 0);
`endif
        sources = 9'h001; step(1); sources = '0;
        step(1);
`ifdef TRACE_TRIG_SEQ_EN
        check("seq_second_stage_trig", trig_out, 1);
`else
        check("seq_second_stage_trig", trig_out, 0);
`endif

        // Heartbeat freezes during a 20-cycle pulse
        reset_n = 1'b0; arm = 1'b0; step(1);
        cfg(2'd0, 9'h001, 16'd0, 8'd20, 8'd0, 1'b1);
        reset_n = 1'b1; step(1);
        arm = 1'b1; step(1);
        sources = 9'h001; step(1); sources = '0;
        step(1);
        check("freeze_rise", trig_out, 1);
        step(8);
        check("freeze_mid_trig", trig_out, 1);
        check("freeze_mid_led", led, 0);
        step(11);
        check("freeze_last_high", trig_out, 1);
        step(1);
        check("freeze_fall", trig_out, 0);
        step(3);
        check("freeze_hb7_led", led, 0);
        step(1);
        check("freeze_hb8_led", led, 1);
        check("freeze_count", trig_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_trig_gen.md
# trace_trig_gen

Parametrised trigger generator for the TraceWhisperer capture path, and the successor of the fixed trigger/LED logic in the top level. It evaluates a configurable set of match-rule and external trigger sources in OR, AND or two-stage sequence mode. It then emits a trigger pulse with programmable delay, width and holdoff, in one-shot or re-arming operation. It also owns the heartbeat LED counter, which is quiet during a trigger, and a saturating trigger counter for host readback. It sits in the trace clock domain between the trace matchers and the trigger output pins.

## Interface
Parameters:
- pNUM_SOURCES, 9: number of trigger sources (pMATCH_RULES matchers plus external target trigger).
- pDELAY_WIDTH, 16: width of the trigger delay count.
- pWIDTH_WIDTH, 8: width of the pulse-width and holdoff counts.
- pCOUNT_WIDTH, 16: width of the trigger event counter.
- pHEARTBEAT_BITS, 23: width of the heartbeat counter.

Ports:
- trace_clk  in  1  sole clock; everything here is in this domain.
- reset_n  in  1  synchronous, active-low reset.
- I_arm  in  1  arm level; a rising edge arms the block, low disarms it.
- I_mode  in  2  0 = OR, 1 = AND, 2 = SEQ (TRIG_SEQ_EN only), 3 = reserved, treated as OR.
- I_mask  in  pNUM_SOURCES  sources participating in the final match.
- I_seq_first  in  pNUM_SOURCES  first-stage source mask for SEQ mode.
- I_sources  in  pNUM_SOURCES  match levels, already synchronous to trace_clk.
- I_delay  in  pDELAY_WIDTH  cycles from match to trigger rise.
- I_pulse_width  in  pWIDTH_WIDTH  trigger high time in cycles; 0 is treated as 1.
- I_holdoff  in  pWIDTH_WIDTH  dead cycles after the pulse.
- I_oneshot  in  1  1 = return to IDLE after the pulse; 0 = re-arm after holdoff.
- O_trig_out  out  1  registered trigger output.
- O_armed  out  1  high in ARMED, SEQ_WAIT or DELAY.
- O_capturing  out  1  high in DELAY or PULSE.
- O_trig_count  out  pCOUNT_WIDTH  number of pulses emitted; saturates.
- O_led_heartbeat  out  1  heartbeat counter MSB.

## Operation
- States: IDLE, ARMED, SEQ_WAIT (macro only), DELAY, PULSE, HOLDOFF.
- Match rules:
  - OR: (I_sources & I_mask) != 0.
  - AND: I_mask != 0 and (I_sources & I_mask) == I_mask.
  - I_mask == 0 never matches.
- IDLE -> ARMED on an I_arm rising edge (edge register reset to 1, so an arm held high through reset does not arm). The same edge clears O_trig_count.
- ARMED -> DELAY on match (or -> SEQ_WAIT on a first-stage hit in SEQ mode).
- DELAY -> PULSE when the delay count expires; PULSE -> HOLDOFF after the width; HOLDOFF -> ARMED (I_oneshot = 0) or IDLE (I_oneshot = 1) when holdoff expires.
- Re-arming after a one-shot requires a new I_arm rising edge.
- I_arm low in any state forces IDLE on the next cycle and drops O_trig_out on the same edge, even mid-pulse.
- A single down-counter is loaded on each state entry. I_delay, I_pulse_width and I_holdoff are sampled at the moment of the load; later changes do not affect the running interval.
- O_trig_count increments on PULSE entry and saturates at all ones.
- The heartbeat counter increments every cycle while O_trig_out is low and holds while it is high. It wraps modulo 2^pHEARTBEAT_BITS.

## Timing
- Reset (reset_n low at a clock edge):
  - State IDLE.
  - All outputs 0.
  - Counters 0.
  - The edge register is set to 1.
- Match sampled at edge t: O_trig_out rises at edge t+1+I_delay. With I_delay = 0 it rises at t+1.
- O_trig_out stays high for max(I_pulse_width, 1) cycles. It is then low for I_holdoff cycles before the next match can be sampled. With holdoff 0, the state is ARMED on the cycle after the pulse falls.
- O_armed and O_capturing are registered decodes of the state, aligned with O_trig_out.
- A match occurring during DELAY, PULSE or HOLDOFF is ignored, not queued.

## Configuration
- TRACE_TRIG_SEQ_EN defined:
  - Mode 2 is SEQ. ARMED -> SEQ_WAIT on (I_sources & I_seq_first) != 0.
  - SEQ_WAIT -> DELAY on an OR match of I_mask, sampled at least one cycle after the first-stage hit; a same-cycle hit does not count.
  - Disarming clears SEQ_WAIT.
- Undefined: the SEQ_WAIT state is not built and mode 2 behaves as OR.

## Structure
- Package trace_trig_pkg holds:
  - the state enum;
  - the mode constants MODE_OR, MODE_AND, MODE_SEQ;
  - the reset value of the edge register.
- One sub-module, trace_trig_match: a purely combinational evaluation of OR, AND and first-stage hits over pNUM_SOURCES. It is instantiated once.
- The state machine, shared down-counter, event counter and heartbeat counter live in trace_trig_gen.

## Test plan
- OR, mask 0x003, delay 5, width 3, oneshot: source 1 pulses at cycle 10 -> O_trig_out high at cycles 16-18; state IDLE afterwards; O_trig_count = 1.
- AND, mask 0x005: source 0 alone, then sources 0 and 2 together -> only the combined hit fires. Delay 0 -> rise one cycle after the combined hit.
- Re-arm mode, holdoff 4, source held high -> pulses repeat every width+holdoff+1 cycles; O_trig_count saturates at 0xFFFF when pCOUNT_WIDTH = 16 is forced near its maximum.
- I_arm dropped mid-PULSE -> O_trig_out low on the next edge, state IDLE. reset_n asserted mid-DELAY -> all outputs 0, and no arm occurs while I_arm stays high.
- SEQ, first mask 0x100, final mask 0x001: final source before first-stage -> no trigger; both in the same cycle -> no trigger; final source one cycle after first-stage -> trigger. With the macro off, the same stimulus fires on the first final-source hit.
- Heartbeat with pHEARTBEAT_BITS = 4 -> LED toggles every 8 cycles and freezes while O_trig_out is high.
